// File: rtl/spi_shift_mlane_pkg.sv
// Shared types and helpers for the multi-lane SPI shift engine.
// Lane modes, default sizes and beat-count arithmetic.
package spi_shift_mlane_pkg;

    typedef enum logic [1:0] {
        LANE_X1  = 2'd0,
        LANE_X2  = 2'd1,
        LANE_X4  = 2'd2,
        LANE_RSV = 2'd3
    } lane_e;

    localparam int MAX_CHAR_DEF = 128;
    localparam int WORD_W_DEF   = 32;

    // log2 of the lane count; the reserved code behaves as x1
    function automatic logic [1:0] lane_shift(input lane_e ln);
        case (ln)
            LANE_X2: return 2'd1;
            LANE_X4: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [15:0] beats(input logic [15:0] nbits,
                                          input lane_e       ln);
        logic [1:0] sh;
        sh = lane_shift(ln);
        return (nbits + ((16'd1 << sh) - 16'd1)) >> sh;
    endfunction

endpackage

// File: rtl/spi_shift_mlane_bitpos.sv
// Lowest data position of the beat selected by a beat counter.
// Result may fall outside 0..nbits-1; callers drop those lanes.
module spi_shift_mlane_bitpos
    import spi_shift_mlane_pkg::*;
#(
    parameter int CW = 8,
    parameter int PW = 11
) (
    input  logic [CW-1:0]        cnt_i,
    input  logic [CW-1:0]        beats_i,
    input  logic [CW-1:0]        nbits_i,
    input  lane_e                lanes_i,
    input  logic                 lsb_i,
    input  logic                 lag_i,
    output logic signed [PW-1:0] base_o
);

    localparam logic signed [PW-1:0] ONE = PW'(1);

    logic [1:0]           sh;
    logic signed [PW-1:0] k;

    assign sh = lane_shift(lanes_i);
    assign k  = $signed(PW'(beats_i)) - $signed(PW'(cnt_i))
              - $signed(PW'(lag_i));

    // MSB-first beats walk down from nbits-1, LSB-first walk up from 0
    assign base_o = lsb_i ? (k <<< sh)
                          : ($signed(PW'(nbits_i)) - ((k + ONE) <<< sh));

endmodule

// File: rtl/spi_shift_mlane.sv
// Multi-lane (x1/x2/x4) SPI shift engine with parallel load,
// configurable char length and bit order, done pulse and abort.
module spi_shift_mlane
    import spi_shift_mlane_pkg::*;
#(
    parameter int MAX_CHAR = MAX_CHAR_DEF,
    parameter int WORD_W   = WORD_W_DEF,
    parameter int LEN_W    = $clog2(MAX_CHAR),
    parameter int IDX_W    = ($clog2(MAX_CHAR / WORD_W) > 0)
                           ? $clog2(MAX_CHAR / WORD_W) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [WORD_W/8-1:0] wr_be,
    input  logic [WORD_W-1:0]   wr_data,
    input  logic [LEN_W-1:0]    len,
    input  logic                lsb,
    input  logic [1:0]          lanes,
    input  logic                dir_rx,
    input  logic                go,
    input  logic                abort,
    input  logic                pos_edge,
    input  logic                neg_edge,
    input  logic                rx_negedge,
    input  logic                tx_negedge,
    input  logic                s_clk,
    input  logic [3:0]          sd_in,
    output logic [3:0]          sd_out,
    output logic [3:0]          sd_oe,
    output logic                tip,
    output logic                last,
    output logic                done,
    output logic [MAX_CHAR-1:0] p_out
);

    localparam int CW    = LEN_W + 1;
    localparam int PW    = LEN_W + 4;
    localparam int NWORD = MAX_CHAR / WORD_W;
    localparam int BE_W  = WORD_W / 8;

    logic                 tip_q, tip_d;
    logic                 done_q, done_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [MAX_CHAR-1:0]  data_q, data_d, load_v;
    logic [3:0]           sd_out_q, sd_out_d;
    logic [LEN_W-1:0]     len_q;
    logic                 lsb_q, dir_q;
    lane_e                lanes_q;

    logic [LEN_W-1:0]     len_e;
    logic                 lsb_e, dir_e;
    lane_e                lanes_e;
    logic [CW-1:0]        nbits_e, beats_e, tx_c;
    logic [3:0]           lane_m, rx_v, beat;
    logic                 neg_x, start, stop;
    logic                 tx_clk, rx_clk, rx_en;
    logic signed [PW-1:0] tx_base, rx_base, nbits_s, tpos, rpos;

    // idle: follow live config; in flight: shadow copy taken on go
    assign len_e   = tip_q ? len_q   : len;
    assign lsb_e   = tip_q ? lsb_q   : lsb;
    assign dir_e   = tip_q ? dir_q   : dir_rx;
    assign lanes_e = tip_q ? lanes_q : lane_e'(lanes);

    assign nbits_e = (len_e == '0) ? CW'(MAX_CHAR)
                                   : CW'(len_e) + CW'(1);
    assign beats_e = CW'(beats(16'(nbits_e), lanes_e));
    assign nbits_s = $signed(PW'(nbits_e));
    assign last    = (cnt_q == '0);
    assign tx_c    = tip_q ? cnt_q : beats_e;

    assign neg_x  = neg_edge && !pos_edge;
    assign start  = go && !tip_q && !abort;
    assign stop   = tip_q && (abort || (pos_edge && last));
    assign tx_clk = tip_q && !abort && !last
                 && (tx_negedge ? neg_x : pos_edge);
    assign rx_clk = tip_q && !abort && (!last || s_clk)
                 && (rx_negedge ? neg_x : pos_edge);
    assign rx_en  = rx_clk && ((lane_m == 4'b0001) || dir_e);

    always_comb begin
        lane_m = 4'b0001;
        unique case (lanes_e)
            LANE_X2: lane_m = 4'b0011;
            LANE_X4: lane_m = 4'b1111;
            default: lane_m = 4'b0001;
        endcase
    end

    assign rx_v = (lane_m == 4'b0001) ? {3'b000, sd_in[1]} : sd_in;

    spi_shift_mlane_bitpos #(.CW(CW), .PW(PW)) u_tx_pos (
        .cnt_i   (tx_c),
        .beats_i (beats_e),
        .nbits_i (nbits_e),
        .lanes_i (lanes_e),
        .lsb_i   (lsb_e),
        .lag_i   (1'b0),
        .base_o  (tx_base)
    );

    spi_shift_mlane_bitpos #(.CW(CW), .PW(PW)) u_rx_pos (
        .cnt_i   (cnt_q),
        .beats_i (beats_e),
        .nbits_i (nbits_e),
        .lanes_i (lanes_e),
        .lsb_i   (lsb_e),
        .lag_i   (rx_negedge),
        .base_o  (rx_base)
    );

    always_comb begin
        tip_d  = tip_q;
        done_d = stop;
        if (start) begin
            tip_d = 1'b1;
        end else if (stop) begin
            tip_d = 1'b0;
        end

        cnt_d = cnt_q;
        if (!tip_q || abort) begin
            cnt_d = beats_e;
        end else if (pos_edge && !last) begin
            cnt_d = cnt_q - CW'(1);
        end

        load_v = data_q;
        if (wr_en && !tip_q) begin
            for (int w = 0; w < NWORD; w++) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (wr_idx == IDX_W'(w) && wr_be[b]) begin
                        load_v[w*WORD_W + b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
            end
        end

        // load_v equals data_q in flight, so tx reads pre-shift data
        beat = 4'b0000;
        tpos = '0;
        for (int j = 0; j < 4; j++) begin
            tpos = tx_base + $signed(PW'(j));
            if (lane_m[j] && !tpos[PW-1] && tpos < nbits_s) begin
                beat[j] = load_v[tpos[LEN_W-1:0]];
            end
        end
        sd_out_d = (tx_clk || !tip_q) ? beat : sd_out_q;

        data_d = load_v;
        rpos   = '0;
        for (int j = 0; j < 4; j++) begin
            rpos = rx_base + $signed(PW'(j));
            if (rx_en && lane_m[j] && !rpos[PW-1] && rpos < nbits_s) begin
                data_d[rpos[LEN_W-1:0]] = rx_v[j];
            end
        end
    end

    always_comb begin
        sd_oe = 4'b0000;
        if (tip_q) begin
            unique case (lanes_q)
                LANE_X2: sd_oe = dir_q ? 4'b0000 : 4'b0011;
                LANE_X4: sd_oe = dir_q ? 4'b0000 : 4'b1111;
                default: sd_oe = 4'b0001;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tip_q    <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            data_q   <= '0;
            sd_out_q <= 4'b0000;
            len_q    <= '0;
            lsb_q    <= 1'b0;
            dir_q    <= 1'b0;
            lanes_q  <= LANE_X1;
        end else begin
            tip_q    <= tip_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            sd_out_q <= sd_out_d;
            if (start) begin
                len_q   <= len;
                lsb_q   <= lsb;
                dir_q   <= dir_rx;
                lanes_q <= lane_e'(lanes);
            end
        end
    end

    assign tip    = tip_q;
    assign done   = done_q;
    assign sd_out = sd_out_q;
    assign p_out  = data_q;

endmodule

// File: tb/tb_spi_shift_mlane.sv
// Directed bench for spi_shift_mlane: x1 loopback, x4 TX, x2 RX,
// full-length x1, abort/restart, ignored load and async reset.
module tb_spi_shift_mlane;

    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, wr_en, lsb, dir_rx, go, abort;
    logic          pos_edge, neg_edge, rx_negedge, tx_negedge, s_clk;
    logic          loop;
    logic [IW-1:0] wr_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [6:0]    len;
    logic [1:0]    lanes;
    logic [3:0]    sd_in_v, sd_in_w, sd_out, sd_oe;
    logic          tip, last, done;
    logic [127:0]  p_out;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  seq;
    logic [31:0] nib;
    logic [11:0] rxv;
    logic        oe_bad;
    int          early, n;

    assign sd_in_w = loop ? {2'b00, sd_out[0], 1'b0} : sd_in_v;

    spi_shift_mlane dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_be      (wr_be),
        .wr_data    (wr_data),
        .len        (len),
        .lsb        (lsb),
        .lanes      (lanes),
        .dir_rx     (dir_rx),
        .go         (go),
        .abort      (abort),
        .pos_edge   (pos_edge),
        .neg_edge   (neg_edge),
        .rx_negedge (rx_negedge),
        .tx_negedge (tx_negedge),
        .s_clk      (s_clk),
        .sd_in      (sd_in_w),
        .sd_out     (sd_out),
        .sd_oe      (sd_oe),
        .tip        (tip),
        .last       (last),
        .done       (done),
        .p_out      (p_out)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_pos;
        pos_edge = 1'b1;
        tick;
        pos_edge = 1'b0;
        s_clk    = 1'b1;
        tick;
    endtask

    task automatic pulse_neg;
        neg_edge = 1'b1;
        tick;
        neg_edge = 1'b0;
        s_clk    = 1'b0;
        tick;
    endtask

    task automatic wr(input logic [IW-1:0] idx, input logic [3:0] be,
                      input logic [31:0] d, input logic g);
        wr_idx  = idx;
        wr_be   = be;
        wr_data = d;
        wr_en   = 1'b1;
        go      = g;
        tick;
        wr_en   = 1'b0;
        go      = 1'b0;
    endtask

    task automatic end_xfer(input string tag);
        pos_edge = 1'b1;
        tick;
        pos_edge = 1'b0;
        check({tag, "_end"}, {tip, done, sd_oe}, {1'b0, 1'b1, 4'h0});
        tick;
        check({tag, "_done1"}, done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_be = '0; wr_data = '0;
        len = '0; lsb = 1'b0; lanes = 2'd0; dir_rx = 1'b0; go = 1'b0;
        abort = 1'b0; pos_edge = 1'b0; neg_edge = 1'b0; rx_negedge = 1'b0;
        tx_negedge = 1'b1; s_clk = 1'b0; loop = 1'b0; sd_in_v = 4'h0;

        tick;
        tick;
        check("rst_ctl", {tip, done, last, sd_oe, sd_out},
              {1'b0, 1'b0, 1'b1, 4'h0, 4'h0});
        check("rst_data", p_out, 128'h0);
        rst_n = 1'b1;
        tick;

        // 1: x1 MSB loopback of 0xA5
        len = 7'd7; loop = 1'b1;
        wr(2'd0, 4'h1, 32'h0000_00A5, 1'b1);
        check("t1_tip", tip, 1'b1);
        check("t1_oe", sd_oe, 4'h1);
        for (int i = 0; i < 8; i++) begin
            seq[7-i] = sd_out[0];
            pulse_pos;
            pulse_neg;
        end
        check("t1_seq", seq, 8'hA5);
        check("t1_last", {tip, last}, 2'b11);
        end_xfer("t1");
        check("t1_rx", p_out, 128'hA5);

        // 2: x4 TX LSB of 0x12345678
        loop = 1'b0; sd_in_v = 4'h0;
        len = 7'd31; lsb = 1'b1; lanes = 2'd2;
        wr(2'd0, 4'hF, 32'h1234_5678, 1'b1);
        oe_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            nib[31-4*i -: 4] = sd_out;
            if (sd_oe !== 4'hF) oe_bad = 1'b1;
            pulse_pos;
            pulse_neg;
        end
        check("t2_nib", nib, 32'h8765_4321);
        check("t2_oe", oe_bad, 1'b0);
        end_xfer("t2");
        check("t2_data", p_out, 128'h1234_5678);

        // 3: x2 RX MSB, 12 bits over a preloaded all-ones word
        wr(2'd0, 4'hF, 32'hFFFF_FFFF, 1'b0);
        len = 7'd11; lsb = 1'b0; lanes = 2'd1; dir_rx = 1'b1;
        go = 1'b1;
        tick;
        go = 1'b0;
        check("t3_tipoe", {tip, sd_oe}, {1'b1, 4'h0});
        rxv = 12'b11_00_10_01_11_00;
        for (int i = 0; i < 6; i++) begin
            sd_in_v = {2'b00, rxv[11-2*i -: 2]};
            pulse_pos;
            pulse_neg;
        end
        end_xfer("t3");
        check("t3_rx", p_out, 128'hFFFF_FC9C);
        dir_rx = 1'b0;

        // 4: len=0 means 128 one-bit beats
        len = 7'd0; lanes = 2'd0; sd_in_v = 4'h0;
        go = 1'b1;
        tick;
        go = 1'b0;
        early = 0;
        for (int i = 0; i < 128; i++) begin
            if (last) early++;
            pulse_pos;
            pulse_neg;
        end
        check("t4_early", early, 0);
        check("t4_last", {tip, last}, 2'b11);
        end_xfer("t4");

        // 5: abort after three edges, go in the same cycle ignored
        wr(2'd0, 4'hF, 32'h0, 1'b0);
        len = 7'd7; sd_in_v = 4'hF;
        go = 1'b1;
        tick;
        go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse_pos;
            pulse_neg;
        end
        abort = 1'b1; go = 1'b1;
        tick;
        abort = 1'b0; go = 1'b0;
        check("t5_abort", {tip, done, sd_oe}, {1'b0, 1'b1, 4'h0});
        check("t5_part", p_out, 128'hE0);
        tick;
        check("t5_idle", {tip, done}, 2'b00);

        go = 1'b1;
        tick;
        go = 1'b0;
        check("t5_restart", tip, 1'b1);

        // 6: load during a transfer is ignored
        wr(2'd0, 4'hF, 32'hDEAD_BEEF, 1'b0);
        check("t6_nowr", p_out, 128'hE0);

        n = 0;
        for (int i = 0; i < 20 && !last; i++) begin
            pulse_pos;
            pulse_neg;
            n++;
        end
        check("t5_count", n, 8);
        check("t5_rx", p_out, 128'hFF);

        // 6: asynchronous reset while tip is still high
        check("t6_pre", {tip, sd_oe}, {1'b1, 4'h1});
        #2;
        rst_n = 1'b0;
        #2;
        check("t6_rst_ctl", {tip, done, last, sd_oe, sd_out},
              {1'b0, 1'b0, 1'b1, 4'h0, 4'h0});
        check("t6_rst_data", p_out, 128'h0);
        tick;
        rst_n = 1'b1;
        tick;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
